// File: rtl/game_scheduler.sv
// game_scheduler
//
// Frame-rate scheduler for the game datapaths. A free-running prescaler produces a
// one-cycle frame tick every TICK_DIV clocks. A small FSM tracks the game phase, and
// while the game is running each client (bullet, ship, alien) gets a one-cycle move
// strobe once every <CLIENT>_DIV frame ticks. The three strobes are staggered one
// cycle apart after the tick, so no two are ever high together.
//
// Ports:
//   clk_12MHz      in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   level; IDLE -> RUN, OVER -> IDLE
//   pause          in   level; game paused while high
//   game_over      in   level; ends the game
//   frame_tick     out  one-cycle pulse every TICK_DIV cycles
//   bullet_enable  out  bullet move strobe (tick + 1)
//   ship_enable    out  ship move strobe (tick + 2)
//   alien_enable   out  alien move strobe (tick + 3)
//   state          out  IDLE=00, RUN=01, PAUSED=10, OVER=11

module game_scheduler #(
  parameter int unsigned TICK_DIV   = 200000,
  parameter int unsigned BULLET_DIV = 1,
  parameter int unsigned SHIP_DIV   = 4,
  parameter int unsigned ALIEN_DIV  = 30
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic       frame_tick,
  output logic       bullet_enable,
  output logic       ship_enable,
  output logic       alien_enable,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
  localparam int unsigned SW = (SHIP_DIV > 1) ? $clog2(SHIP_DIV) : 1;
  localparam int unsigned AW = (ALIEN_DIV > 1) ? $clog2(ALIEN_DIV) : 1;

  localparam logic [PW-1:0] PrescMax    = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BulletReload = BW'(BULLET_DIV - 1);
  localparam logic [SW-1:0] ShipReload   = SW'(SHIP_DIV - 1);
  localparam logic [AW-1:0] AlienReload  = AW'(ALIEN_DIV - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10,
    StOver   = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [BW-1:0]   b_cnt_q, b_cnt_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [AW-1:0]   a_cnt_q, a_cnt_d;
  logic            b_pend_q, b_pend_d;
  logic            s_pend_q, s_pend_d;
  logic            a_pend_q, a_pend_d;
  // Delayed copies of the tick: bit 0 is tick+1, bit 1 tick+2, bit 2 tick+3.
  logic [2:0]      phase_q;

  logic tick_raw;
  logic running;
  logic frame_run;
  logic b_set, s_set, a_set;
  logic b_fire, s_fire, a_fire;

  // ---------------------------------------------------------------------------
  // Prescaler (runs in every state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      presc_q <= '0;
      phase_q <= '0;
    end else begin
      presc_q <= (presc_q == PrescMax) ? '0 : presc_q + PW'(1);
      phase_q <= {phase_q[1:0], tick_raw};
    end
  end

  assign tick_raw   = (presc_q == PrescMax);
  assign frame_tick = tick_raw & ~reset;

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun: begin
        if (game_over) state_d = StOver;
        else if (pause) state_d = StPaused;
      end
      StPaused: begin
        if (game_over) state_d = StOver;
        else if (!pause) state_d = StRun;
      end
      StOver:   if (start) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reset gates the visible state and strobes in the very cycle it is asserted.
  assign running   = (state_q == StRun) & ~reset;
  assign frame_run = (state_q == StRun) & tick_raw;
  assign state     = reset ? StIdle : state_q;

  // ---------------------------------------------------------------------------
  // Per-client frame counters: cleared in IDLE so the first RUN tick fires all
  // clients, counted only on RUN ticks, held otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    b_cnt_d = b_cnt_q;
    b_set   = 1'b0;
    if (state_q == StIdle) begin
      b_cnt_d = '0;
    end else if (frame_run) begin
      if (b_cnt_q == '0) begin
        b_set   = 1'b1;
        b_cnt_d = BulletReload;
      end else begin
        b_cnt_d = b_cnt_q - BW'(1);
      end
    end
  end

  always_comb begin
    s_cnt_d = s_cnt_q;
    s_set   = 1'b0;
    if (state_q == StIdle) begin
      s_cnt_d = '0;
    end else if (frame_run) begin
      if (s_cnt_q == '0) begin
        s_set   = 1'b1;
        s_cnt_d = ShipReload;
      end else begin
        s_cnt_d = s_cnt_q - SW'(1);
      end
    end
  end

  always_comb begin
    a_cnt_d = a_cnt_q;
    a_set   = 1'b0;
    if (state_q == StIdle) begin
      a_cnt_d = '0;
    end else if (frame_run) begin
      if (a_cnt_q == '0) begin
        a_set   = 1'b1;
        a_cnt_d = AlienReload;
      end else begin
        a_cnt_d = a_cnt_q - AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags and staggered strobes. TICK_DIV >= 4 guarantees a flag is never
  // set and fired in the same cycle. Any non-RUN cycle drops every pending move.
  // ---------------------------------------------------------------------------
  assign b_fire = running & phase_q[0] & b_pend_q;
  assign s_fire = running & phase_q[1] & s_pend_q;
  assign a_fire = running & phase_q[2] & a_pend_q;

  always_comb begin
    b_pend_d = b_pend_q;
    s_pend_d = s_pend_q;
    a_pend_d = a_pend_q;
    if (state_q != StRun) begin
      b_pend_d = 1'b0;
      s_pend_d = 1'b0;
      a_pend_d = 1'b0;
    end else begin
      if (b_set) b_pend_d = 1'b1;
      else if (b_fire) b_pend_d = 1'b0;
      if (s_set) s_pend_d = 1'b1;
      else if (s_fire) s_pend_d = 1'b0;
      if (a_set) a_pend_d = 1'b1;
      else if (a_fire) a_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      b_cnt_q  <= '0;
      s_cnt_q  <= '0;
      a_cnt_q  <= '0;
      b_pend_q <= 1'b0;
      s_pend_q <= 1'b0;
      a_pend_q <= 1'b0;
    end else begin
      b_cnt_q  <= b_cnt_d;
      s_cnt_q  <= s_cnt_d;
      a_cnt_q  <= a_cnt_d;
      b_pend_q <= b_pend_d;
      s_pend_q <= s_pend_d;
      a_pend_q <= a_pend_d;
    end
  end

  assign bullet_enable = b_fire;
  assign ship_enable   = s_fire;
  assign alien_enable  = a_fire;

endmodule

// File: tb/tb_game_scheduler.sv
module tb_game_scheduler;

  logic       clk_12MHz = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       game_over;
  logic       frame_tick;
  logic       bullet_enable;
  logic       ship_enable;
  logic       alien_enable;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  game_scheduler #(
    .TICK_DIV  (8),
    .BULLET_DIV(1),
    .SHIP_DIV  (2),
    .ALIEN_DIV (3)
  ) dut (
    .clk_12MHz    (clk_12MHz),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .game_over    (game_over),
    .frame_tick   (frame_tick),
    .bullet_enable(bullet_enable),
    .ship_enable  (ship_enable),
    .alien_enable (alien_enable),
    .state        (state)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Enter the next cycle; inputs driven here are sampled at the following edge.
  task automatic cyc();
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic check_state(input logic [1:0] exp, input string name);
    n_tests++;
    if (state !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %b expected %b", name, state, exp);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick: frame_tick got none expected pulse within 20 cycles");
    end
  endtask

  // Wait for a tick, then check {bullet,ship,alien} at T+1, T+2, T+3.
  task automatic run_tick(input logic eb, input logic es, input logic ea, input string name);
    bit         ok;
    logic [2:0] got;
    logic [2:0] exp;
    wait_tick(ok);
    if (ok) begin
      for (int j = 1; j <= 3; j++) begin
        cyc();
        #1;
        got = {bullet_enable, ship_enable, alien_enable};
        exp = (j == 1) ? {eb, 2'b00} : (j == 2) ? {1'b0, es, 1'b0} : {2'b00, ea};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s T+%0d: strobes got %b expected %b", name, j, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic exp_tick;
    reset = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      n_tests++;
      if ({frame_tick, bullet_enable, ship_enable, alien_enable, state} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs got %b expected 000000",
                 {frame_tick, bullet_enable, ship_enable, alien_enable, state});
      end
    end
    cyc();
    reset = 1'b0;
    #1;
    check_state(2'b00, "release_state");
    n_tests++;
    if ({frame_tick, bullet_enable, ship_enable, alien_enable} !== 4'b0) begin
      n_fail++;
      $display("FAIL release_outputs: got %b expected 0000",
               {frame_tick, bullet_enable, ship_enable, alien_enable});
    end
    for (int k = 2; k <= 24; k++) begin
      cyc();
      #1;
      exp_tick = ((k % 8) == 0);
      n_tests++;
      if (frame_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL tick_period cycle %0d: frame_tick got %b expected %b",
                 k, frame_tick, exp_tick);
      end
    end
  endtask

  task automatic test_run();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check_state(2'b01, "start_to_run");
    run_tick(1'b1, 1'b1, 1'b1, "run_tick1");
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check_state(2'b01, "start_ignored_in_run");
    run_tick(1'b1, 1'b0, 1'b0, "run_tick2");
    run_tick(1'b1, 1'b1, 1'b0, "run_tick3");
    run_tick(1'b1, 1'b0, 1'b1, "run_tick4");
    run_tick(1'b1, 1'b1, 1'b0, "run_tick5");
    run_tick(1'b1, 1'b0, 1'b0, "run_tick6");
  endtask

  task automatic test_pause();
    bit ok;
    wait_tick(ok);
    cyc();
    pause = 1'b1;
    #1;
    n_tests++;
    if ({bullet_enable, ship_enable, alien_enable} !== 3'b100) begin
      n_fail++;
      $display("FAIL pause_T1: strobes got %b expected 100",
               {bullet_enable, ship_enable, alien_enable});
    end
    for (int j = 2; j <= 3; j++) begin
      cyc();
      #1;
      check_state(2'b10, "pause_state");
      n_tests++;
      if ({bullet_enable, ship_enable, alien_enable} !== 3'b000) begin
        n_fail++;
        $display("FAIL pause_T%0d: strobes got %b expected 000",
                 j, {bullet_enable, ship_enable, alien_enable});
      end
    end
    run_tick(1'b0, 1'b0, 1'b0, "paused_tick");
    check_state(2'b10, "still_paused");
    pause = 1'b0;
    run_tick(1'b1, 1'b0, 1'b0, "resume_tick1");
    run_tick(1'b1, 1'b1, 1'b0, "resume_tick2");
    run_tick(1'b1, 1'b0, 1'b1, "resume_tick3");
  endtask

  task automatic test_over();
    game_over = 1'b1;
    pause     = 1'b1;
    cyc();
    game_over = 1'b0;
    pause     = 1'b0;
    #1;
    check_state(2'b11, "over_priority");
    run_tick(1'b0, 1'b0, 1'b0, "over_tick");
    check_state(2'b11, "over_holds");
  endtask

  task automatic test_restart();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check_state(2'b00, "over_to_idle");
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check_state(2'b01, "idle_to_run");
    run_tick(1'b1, 1'b1, 1'b1, "restart_tick1");
  endtask

  task automatic test_reset_inflight();
    bit   ok;
    logic any_strobe;
    int   tick_at;
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check_state(2'b01, "inflight_run");
    wait_tick(ok);
    cyc();
    #1;
    n_tests++;
    if (bullet_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_bullet: got %b expected 1", bullet_enable);
    end
    cyc();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({frame_tick, bullet_enable, ship_enable, alien_enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL inflight_reset_T2: outputs got %b expected 0000",
               {frame_tick, bullet_enable, ship_enable, alien_enable});
    end
    check_state(2'b00, "inflight_reset_state");
    cyc();
    reset = 1'b0;
    #1;
    n_tests++;
    if (alien_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_alien: got %b expected 0", alien_enable);
    end
    check_state(2'b00, "after_reset_state");
    any_strobe = 1'b0;
    tick_at    = 0;
    for (int k = 2; k <= 20; k++) begin
      cyc();
      #1;
      any_strobe = any_strobe | bullet_enable | ship_enable | alien_enable;
      if (frame_tick === 1'b1) begin
        tick_at = k;
        break;
      end
    end
    n_tests++;
    if (tick_at != 8) begin
      n_fail++;
      $display("FAIL reset_realign: first tick got cycle %0d expected cycle 8", tick_at);
    end
    n_tests++;
    if (any_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_strobe: got %b expected 0", any_strobe);
    end
    check_state(2'b00, "idle_after_reset");
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_over();
    test_restart();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
